mem_writer: RTL and testbench
=============================

MEM_WRITER -- requirements
Module: mem_writer

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, memory data width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 16, memory address width in bits.
REQ-003 The module SHALL have parameter LAST_ADDR, default 35000, final address of one load pass.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port start, input, 1 bit: one-cycle request to begin a load pass.
REQ-007 The module SHALL have port abort, input, 1 bit: synchronous cancel of the current pass.
REQ-008 The module SHALL have port in_data, input, DATA_W bits: stream word to store.
REQ-009 The module SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-010 The module SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-011 The module SHALL have port mem_addr, output, ADDR_W bits: memory write address.
REQ-012 The module SHALL have port mem_wdata, output, DATA_W bits: memory write data.
REQ-013 The module SHALL have port mem_we, output, 1 bit: one-cycle memory write strobe.
REQ-014 The module SHALL have port done, output, 1 bit: high while a completed pass is held.
REQ-015 The module SHALL have port overrun, output, 1 bit: sticky flag for a word offered after completion.

Function
REQ-016 The FSM SHALL have three states, IDLE, LOAD and DONE, with IDLE as the reset state.
REQ-017 A handshake SHALL occur when in_valid and in_ready are both 1 on a rising clk edge.
REQ-018 in_ready SHALL be a registered output that is 1 only in LOAD.
REQ-019 In IDLE, start=1 SHALL move the FSM to LOAD and clear the write pointer to 0.
REQ-020 In LOAD, each handshake SHALL, in the following cycle, drive mem_we=1 for exactly one cycle, with mem_addr equal to the write pointer and mem_wdata equal to the accepted in_data, and SHALL increment the write pointer.
REQ-021 Write latency from handshake to mem_we SHALL be exactly 1 cycle.
REQ-022 mem_addr and mem_wdata SHALL hold their last values while mem_we=0.
REQ-023 A handshake with write pointer equal to LAST_ADDR SHALL write that address, move the FSM to DONE and clear in_ready in the next cycle.
REQ-024 A complete pass SHALL therefore write exactly LAST_ADDR+1 words, to addresses 0 through LAST_ADDR in order, with no wrap past LAST_ADDR.
REQ-025 done SHALL be 1 in DONE and 0 in every other state.
REQ-026 In DONE, start=1 SHALL begin a new pass: FSM to LOAD, pointer to 0, done to 0, overrun cleared.
REQ-027 start in LOAD SHALL be ignored.
REQ-028 abort=1 SHALL move the FSM from any state to IDLE in the next cycle.
REQ-029 abort SHALL have priority over both start and any handshake in the same cycle; no write is issued for a word offered in that cycle.
REQ-030 in_valid=1 while in DONE SHALL set overrun=1; overrun stays set until reset, start or abort.
REQ-031 in_valid while in IDLE SHALL be ignored and SHALL NOT set overrun.
REQ-032 The write pointer SHALL be ADDR_W bits wide, and LAST_ADDR SHALL be less than 2^ADDR_W.

Reset
REQ-033 While reset=0, the block SHALL immediately force: state IDLE, write pointer 0, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, done 0, overrun 0.
REQ-034 Reset asserted mid-pass SHALL cancel the pass with no further mem_we pulse.
REQ-035 After reset is released, the block SHALL wait in IDLE for start.

Structure
REQ-036 The state enumeration and the LAST_ADDR default constant SHALL live in the shared package mem_pkg.
REQ-037 The write pointer with clear, increment and last-address compare SHALL be one sub-module, wr_addr_gen; the FSM and output registers SHALL remain in mem_writer.

Verification
REQ-038 Scenario: reset low, then start, then continuous in_valid with in_data = address[7:0] -> 35001 mem_we pulses at addresses 0..35000 with matching data, then done=1 and in_ready=0.
REQ-039 Scenario: in LOAD, in_valid toggled every other cycle -> mem_we appears exactly 1 cycle after each handshake, with no address skipped or repeated.
REQ-040 Scenario: abort asserted at pointer 100 together with in_valid -> no write at address 100, IDLE next cycle, in_ready=0.
REQ-041 Scenario: in DONE, in_valid=1 for 1 cycle -> overrun=1; start -> overrun=0, done=0, next write at address 0.
REQ-042 Scenario: reset driven low mid-pass between clock edges -> all outputs 0 immediately, with no mem_we afterwards until a new start.
REQ-043 Scenario: LAST_ADDR=3, start pulsed while in LOAD -> start ignored; exactly 4 writes to addresses 0..3, then DONE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the streaming memory writer.
// Holds the FSM state encoding and the default final address of a load pass.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned LAST_ADDR_DEF = 35000;

endpackage

// File: rtl/mem_writer_wr_addr_gen.sv
// Write pointer for mem_writer: clear, increment and last-address compare.
// The pointer saturates at LAST_ADDR so a pass never wraps.
module wr_addr_gen
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned LAST_ADDR = LAST_ADDR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr,
    output logic              at_last
);

    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] ptr_r;

    // Pointer register; clear wins over increment, increment stops at the last address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= '0;
        end else if (clr) begin
            ptr_r <= '0;
        end else if (inc && (ptr_r != LAST_A)) begin
            ptr_r <= ptr_r + PTR_ONE;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr     = ptr_r;
    assign at_last = (ptr_r == LAST_A);

endmodule

// File: rtl/mem_writer.sv
// Streams words from a valid/ready input into consecutive memory addresses
// 0..LAST_ADDR, one registered write strobe per accepted word.
module mem_writer
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned LAST_ADDR = LAST_ADDR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              done,
    output logic              overrun
);

    state_t            state_r;
    state_t            next_state_s;

    logic              in_ready_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              mem_we_r;
    logic              done_r;
    logic              overrun_r;

    logic              ready_nxt_s;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic [DATA_W-1:0] wdata_nxt_s;
    logic              we_nxt_s;
    logic              done_nxt_s;
    logic              overrun_nxt_s;

    logic              accept_s;
    logic              clr_s;
    logic [ADDR_W-1:0] ptr_s;
    logic              at_last_s;

    // abort suppresses the handshake so a word offered alongside it is dropped
    assign accept_s = in_valid && in_ready_r && !abort;
    assign clr_s    = start && !abort && (state_r != ST_LOAD);

    wr_addr_gen #(
        .ADDR_W    (ADDR_W),
        .LAST_ADDR (LAST_ADDR)
    ) u_wr_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_s),
        .inc     (accept_s),
        .ptr     (ptr_s),
        .at_last (at_last_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        next_state_s = state_r;
        if (abort) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) next_state_s = ST_LOAD;
                    else       next_state_s = ST_IDLE;
                end
                ST_LOAD: begin
                    if (accept_s && at_last_s) next_state_s = ST_DONE;
                    else                       next_state_s = ST_LOAD;
                end
                ST_DONE: begin
                    if (start) next_state_s = ST_LOAD;
                    else       next_state_s = ST_DONE;
                end
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // Output logic: next values for the registered outputs.
    always_comb begin
        ready_nxt_s   = 1'b0;
        addr_nxt_s    = mem_addr_r;
        wdata_nxt_s   = mem_wdata_r;
        we_nxt_s      = 1'b0;
        done_nxt_s    = 1'b0;
        overrun_nxt_s = overrun_r;

        if (next_state_s == ST_LOAD) ready_nxt_s = 1'b1;
        else                         ready_nxt_s = 1'b0;

        if (next_state_s == ST_DONE) done_nxt_s = 1'b1;
        else                         done_nxt_s = 1'b0;

        if (accept_s) begin
            we_nxt_s    = 1'b1;
            addr_nxt_s  = ptr_s;
            wdata_nxt_s = in_data;
        end else begin
            we_nxt_s    = 1'b0;
        end

        if (abort) begin
            overrun_nxt_s = 1'b0;
        end else if (start && (state_r != ST_LOAD)) begin
            overrun_nxt_s = 1'b0;
        end else if ((state_r == ST_DONE) && in_valid) begin
            overrun_nxt_s = 1'b1;
        end else begin
            overrun_nxt_s = overrun_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_r  <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_we_r    <= 1'b0;
            done_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            in_ready_r  <= ready_nxt_s;
            mem_addr_r  <= addr_nxt_s;
            mem_wdata_r <= wdata_nxt_s;
            mem_we_r    <= we_nxt_s;
            done_r      <= done_nxt_s;
            overrun_r   <= overrun_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_we    = mem_we_r;
    assign done      = done_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_mem_writer.sv
// Scoreboard bench for mem_writer: a default-size instance for the full pass
// and a LAST_ADDR=3 instance for the short-pass case.
module tb_mem_writer;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start_a = 1'b0, abort_a = 1'b0, in_valid_a = 1'b0;
    logic [7:0]  in_data_a = 8'h00;
    logic        in_ready_a, mem_we_a, done_a, overrun_a;
    logic [15:0] mem_addr_a;
    logic [7:0]  mem_wdata_a;

    logic        start_b = 1'b0, abort_b = 1'b0, in_valid_b = 1'b0;
    logic [7:0]  in_data_b = 8'h00;
    logic        in_ready_b, mem_we_b, done_b, overrun_b;
    logic [15:0] mem_addr_b;
    logic [7:0]  mem_wdata_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wcnt_a = 0;
    int wcnt_b = 0;
    int ptr = 0;
    wr_t qa[$];
    wr_t qb[$];

    mem_writer dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a),
        .done(done_a), .overrun(overrun_a)
    );

    mem_writer #(.DATA_W(8), .ADDR_W(16), .LAST_ADDR(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b),
        .done(done_b), .overrun(overrun_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the default instance: every write strobe must match the queue head.
    always @(negedge clk) begin
        if (mem_we_a === 1'b1) begin
            wcnt_a++;
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write_a: got addr %0d data %0d expected no write", mem_addr_a, mem_wdata_a);
            end else begin
                wr_t e;
                e = qa.pop_front();
                chk("wr_addr_a", int'(mem_addr_a), e.addr);
                chk("wr_data_a", int'(mem_wdata_a), e.data);
                chk("wr_cycle_a", cyc, e.cyc);
            end
        end
    end

    // Monitor for the LAST_ADDR=3 instance.
    always @(negedge clk) begin
        if (mem_we_b === 1'b1) begin
            wcnt_b++;
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write_b: got addr %0d data %0d expected no write", mem_addr_b, mem_wdata_b);
            end else begin
                wr_t e;
                e = qb.pop_front();
                chk("wr_addr_b", int'(mem_addr_b), e.addr);
                chk("wr_data_b", int'(mem_wdata_b), e.data);
                chk("wr_cycle_b", cyc, e.cyc);
            end
        end
    end

    initial begin
        // reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready_a), 0);
        chk("rst_mem_we", int'(mem_we_a), 0);
        chk("rst_mem_addr", int'(mem_addr_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_overrun", int'(overrun_a), 0);
        repeat (2) tick();
        @(negedge clk) reset = 1'b1;

        // in_valid in IDLE is ignored
        in_valid_a = 1'b1;
        in_data_a  = 8'h55;
        repeat (3) tick();
        in_valid_a = 1'b0;
        chk("idle_in_ready", int'(in_ready_a), 0);
        chk("idle_overrun", int'(overrun_a), 0);

        // full pass with in_data = address[7:0]
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("load_in_ready", int'(in_ready_a), 1);
        chk("load_done", int'(done_a), 0);
        for (int a = 0; a <= 35000; a++) begin
            in_valid_a = 1'b1;
            in_data_a  = a[7:0];
            qa.push_back('{a, a % 256, cyc + 1});
            tick();
        end
        in_valid_a = 1'b0;
        chk("pass_done", int'(done_a), 1);
        chk("pass_in_ready", int'(in_ready_a), 0);
        tick();
        chk("pass_we_low", int'(mem_we_a), 0);
        chk("pass_addr_hold", int'(mem_addr_a), 35000);
        chk("pass_data_hold", int'(mem_wdata_a), 184);
        chk("pass_writes", wcnt_a, 35001);
        chk("pass_done_hold", int'(done_a), 1);

        // overrun in DONE, cleared by a new start
        in_valid_a = 1'b1;
        in_data_a  = 8'h77;
        tick();
        in_valid_a = 1'b0;
        chk("overrun_set", int'(overrun_a), 1);
        tick();
        chk("overrun_sticky", int'(overrun_a), 1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("restart_overrun", int'(overrun_a), 0);
        chk("restart_done", int'(done_a), 0);
        chk("restart_in_ready", int'(in_ready_a), 1);
        in_valid_a = 1'b1;
        in_data_a  = 8'hA5;
        qa.push_back('{0, 165, cyc + 1});
        tick();
        ptr = 1;

        // in_valid toggling every other cycle
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                in_valid_a = 1'b1;
                in_data_a  = 8'(8'h10 + i);
                qa.push_back('{ptr, 16 + i, cyc + 1});
                ptr++;
            end else begin
                in_valid_a = 1'b0;
            end
            tick();
        end

        // run to pointer 100, then abort together with a word
        while (ptr < 100) begin
            in_valid_a = 1'b1;
            in_data_a  = 8'(ptr);
            qa.push_back('{ptr, ptr % 256, cyc + 1});
            ptr++;
            tick();
        end
        in_valid_a = 1'b1;
        in_data_a  = 8'hEE;
        abort_a    = 1'b1;
        tick();
        abort_a    = 1'b0;
        in_valid_a = 1'b0;
        chk("abort_in_ready", int'(in_ready_a), 0);
        chk("abort_we", int'(mem_we_a), 0);
        chk("abort_done", int'(done_a), 0);
        chk("abort_addr_hold", int'(mem_addr_a), 99);
        repeat (3) tick();

        // reset mid-pass between edges
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid_a = 1'b1;
            in_data_a  = 8'(8'hC0 + i);
            qa.push_back('{i, 192 + i, cyc + 1});
            tick();
        end
        in_valid_a = 1'b0;
        tick();
        @(negedge clk);
        #1;
        in_valid_a = 1'b1;
        reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", int'(in_ready_a), 0);
        chk("mid_rst_addr", int'(mem_addr_a), 0);
        chk("mid_rst_data", int'(mem_wdata_a), 0);
        chk("mid_rst_we", int'(mem_we_a), 0);
        chk("mid_rst_done", int'(done_a), 0);
        repeat (3) tick();
        @(negedge clk) reset = 1'b1;
        repeat (4) tick();
        in_valid_a = 1'b0;
        chk("post_rst_in_ready", int'(in_ready_a), 0);

        // short pass with start pulsed while loading
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_in_ready", int'(in_ready_b), 1);
        for (int i = 0; i < 4; i++) begin
            in_valid_b = 1'b1;
            in_data_b  = 8'(8'h30 + i);
            start_b    = (i == 1);
            qb.push_back('{i, 48 + i, cyc + 1});
            tick();
        end
        in_valid_b = 1'b0;
        start_b    = 1'b0;
        chk("b_done", int'(done_b), 1);
        chk("b_in_ready_low", int'(in_ready_b), 0);
        repeat (2) tick();
        chk("b_done_hold", int'(done_b), 1);
        chk("b_writes", wcnt_b, 4);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
